// File: rtl/seg7_scroll_mux.sv
// seg7_scroll_mux: scrolling hex display with a stepped 4-bit value, multiplexed over NUM_DIGITS digits.
// Optional feature: define SEG7_SCROLL_BLINK_EN to add a blink input that blanks seg in the second half of each step.
module seg7_scroll_mux #(
    parameter int STEP_DIV   = 25000000,
    parameter int SCAN_DIV   = 1000,
    parameter int NUM_DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    input  logic                  dir,
    input  logic                  load,
    input  logic [3:0]            load_val,
`ifdef SEG7_SCROLL_BLINK_EN
    input  logic                  blink,
`endif
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] dig_en,
    output logic                  step
);

    localparam int PW = $clog2(STEP_DIV);
    localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;

    // Character glyphs 0..F, bit6=g ... bit0=a
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic [PW-1:0]         r_pre;
    logic [3:0]            r_val;
    logic                  r_step;
    logic [SW-1:0]         r_scan;
    logic [IW-1:0]         r_idx;
    logic [6:0]            r_seg;
    logic [NUM_DIGITS-1:0] r_dig;

    logic                  w_pre_tc;
    logic                  w_scan_tc;
    logic                  w_adv;
    logic                  w_blank;
    logic [3:0]            w_chr;

    assign w_pre_tc  = r_pre == PW'(STEP_DIV - 1);
    assign w_scan_tc = r_scan == SW'(SCAN_DIV - 1);
    assign w_adv     = run && w_pre_tc && !load;
    assign w_chr     = r_val + 4'(r_idx);

`ifdef SEG7_SCROLL_BLINK_EN
    assign w_blank = blink && (r_pre >= PW'(STEP_DIV / 2));
`else
    assign w_blank = 1'b0;
`endif

    // Step prescaler and displayed value; a load clears the prescaler and suppresses a coincident step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre  <= '0;
            r_val  <= '0;
            r_step <= 1'b0;
        end else begin
            r_pre  <= (load || (run && w_pre_tc)) ? '0 : run ? r_pre + 1'b1 : r_pre;
            r_val  <= load ? load_val : w_adv ? (dir ? r_val - 1'b1 : r_val + 1'b1) : r_val;
            r_step <= w_adv;
        end
    end

    // Digit scan runs continuously, independent of run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan <= '0;
            r_idx  <= '0;
        end else begin
            r_scan <= w_scan_tc ? '0 : r_scan + 1'b1;
            r_idx  <= !w_scan_tc ? r_idx : (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
        end
    end

    // Segments and digit select register together so a select never pairs with another digit's glyph
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= 7'h3F;
            r_dig <= NUM_DIGITS'(1);
        end else begin
            r_seg <= w_blank ? 7'h00 : SEG_LUT[w_chr];
            r_dig <= NUM_DIGITS'(1) << r_idx;
        end
    end

    assign seg    = r_seg;
    assign dig_en = r_dig;
    assign step   = r_step;

endmodule
